load_unit: RTL and testbench
============================

Name: load_unit

Overview:
- Load-extraction unit feeding the data-memory writeback stage.
- Takes the 32-bit word read from word-addressed data memory plus the byte offset, and produces the sign- or zero-extended load result combinationally.
- Also keeps a small registered status block: a sticky misalignment fault flag with its faulting byte address, and a count of executed loads.

Parameters:
- CNT_W, 16, width of the executed-load counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- addr_data  input  32  word read from memory at word address alu_result>>2.
- addr_rem  input  2  byte offset within the word; must equal alu_result[1:0].
- alu_result  input  32  full byte address of the access.
- info_load  input  3  load type.
- data  output  32  extracted and extended load result (combinational).
- misaligned  output  1  combinational: current access is misaligned.
- fault  output  1  registered, sticky misalignment fault.
- fault_addr  output  32  registered byte address of the first fault.
- load_cnt  output  CNT_W  registered count of valid loads.

Behaviour:
- info_load encoding:
  - 0 none
  - 1 LB
  - 2 LH
  - 3 LW
  - 4 LBU
  - 5 LHU
  - 6 and 7 reserved, treated as none.
- Byte lanes: lane k = addr_data[8k+7:8k], where lane 0 is the least significant byte.
- data, purely combinational with zero latency:
  - none/reserved: 0.
  - LB: lane[addr_rem] sign-extended from bit 7.
  - LBU: lane[addr_rem] zero-extended.
  - LH/LHU with addr_rem 0: addr_data[15:0]. addr_rem 1: addr_data[23:8]. addr_rem 2: addr_data[31:16]. Result is sign-extended from bit 15 (LH) or zero-extended (LHU).
  - LH/LHU with addr_rem 3: the halfword would cross the word boundary. data = 0.
  - LW: addr_data unchanged, regardless of addr_rem.
- misaligned, combinational:
  - 1 for LH/LHU with addr_rem = 3.
  - 1 for LW with addr_rem != 0.
  - 0 otherwise, including byte loads and none.
- Registered state, updated on rising clk:
  - rst = 1 asynchronously forces fault = 0, fault_addr = 0, load_cnt = 0, at any time including mid-sequence.
  - If misaligned and fault = 0: fault <= 1 and fault_addr <= alu_result.
  - Once fault = 1, it and fault_addr hold until reset. Later faults do not overwrite them.
  - If info_load is in 1..5: load_cnt <= load_cnt + 1, wrapping modulo 2^CNT_W. Misaligned loads are counted too.
- The data path does not depend on clk/rst. data is valid in the same cycle as its inputs, so the enclosing stage registers it on the same edge.
- alu_result[31:2] is not used for extraction. Only addr_rem selects lanes.

Test Plan:
- addr_data = 0x8877_66F5, LB at rem 0 -> data 0xFFFF_FFF5. LBU at rem 0 -> 0x0000_00F5. LB at rem 3 -> 0xFFFF_FF88. LBU at rem 2 -> 0x0000_0077.
- addr_data = 0x8001_7FFF:
  - LH at rem 0 -> 0x0000_7FFF.
  - LH at rem 2 -> 0xFFFF_8001.
  - LHU at rem 2 -> 0x0000_8001.
  - LH at rem 1 -> 0x0000_017F.
  - LH at rem 3 -> data 0 and misaligned = 1.
- LW of 0xDEAD_BEEF at rem 0 -> 0xDEAD_BEEF, misaligned = 0. LW at rem 2 -> 0xDEAD_BEEF, misaligned = 1.
- Misaligned LW at alu_result 0x0000_1002, clock edge -> fault = 1, fault_addr = 0x0000_1002. Then misaligned LH at 0x0000_2003 -> fault_addr stays 0x0000_1002. Assert rst between edges -> all three registers 0 immediately.
- Five cycles of info_load = 1,0,3,6,5 -> load_cnt = 3. With CNT_W = 2, six valid loads -> load_cnt = 2 (wrap). info_load 6 or 7 -> data 0.

Source files
------------

// File: rtl/load_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : load_unit_if
// Purpose  : Bus bundle between the writeback stage and the load extractor.
// Revision : 1.0  initial release
// ============================================================================
interface load_unit_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      addr_data;
    logic [1:0]       addr_rem;
    logic [31:0]      alu_result;
    logic [2:0]       info_load;
    logic [31:0]      data;
    logic             misaligned;
    logic             fault;
    logic [31:0]      fault_addr;
    logic [CNT_W-1:0] load_cnt;

    modport master (
        output addr_data, addr_rem, alu_result, info_load,
        input  data, misaligned, fault, fault_addr, load_cnt
    );

    modport slave (
        input  addr_data, addr_rem, alu_result, info_load,
        output data, misaligned, fault, fault_addr, load_cnt
    );
endinterface
`default_nettype wire

// File: rtl/load_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_unit
// Purpose  : Combinational load extraction plus sticky misalignment fault
//            capture and an executed-load counter.
// Revision : 1.0  initial release
// ============================================================================
module load_unit #(
    parameter int CNT_W = 16
) (
    input  wire logic   clk,
    input  wire logic   rst,
    load_unit_if.slave  bus
);
    localparam logic [2:0] c_LD_NONE = 3'd0;
    localparam logic [2:0] c_LD_LB   = 3'd1;
    localparam logic [2:0] c_LD_LH   = 3'd2;
    localparam logic [2:0] c_LD_LW   = 3'd3;
    localparam logic [2:0] c_LD_LBU  = 3'd4;
    localparam logic [2:0] c_LD_LHU  = 3'd5;

    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [31:0]      w_data;
    logic             w_misaligned;
    logic             w_valid;
    logic             r_fault;
    logic [31:0]      r_fault_addr;
    logic [CNT_W-1:0] r_load_cnt;

    always_comb begin
        w_byte = 8'h00;
        w_half = 16'h0000;
        case (bus.addr_rem)
            2'd0: begin w_byte = bus.addr_data[7:0];   w_half = bus.addr_data[15:0];  end
            2'd1: begin w_byte = bus.addr_data[15:8];  w_half = bus.addr_data[23:8];  end
            2'd2: begin w_byte = bus.addr_data[23:16]; w_half = bus.addr_data[31:16]; end
            default: begin w_byte = bus.addr_data[31:24]; w_half = 16'h0000; end
        endcase
    end

    always_comb begin
        w_data       = 32'h0000_0000;
        w_misaligned = 1'b0;
        w_valid      = 1'b1;
        case (bus.info_load)
            c_LD_LB:  w_data = {{24{w_byte[7]}}, w_byte};
            c_LD_LBU: w_data = {24'h000000, w_byte};
            c_LD_LH: begin
                w_data       = {{16{w_half[15]}}, w_half};
                w_misaligned = (bus.addr_rem == 2'd3);
            end
            c_LD_LHU: begin
                w_data       = {16'h0000, w_half};
                w_misaligned = (bus.addr_rem == 2'd3);
            end
            c_LD_LW: begin
                w_data       = bus.addr_data;
                w_misaligned = (bus.addr_rem != 2'd0);
            end
            default: w_valid = 1'b0;
        endcase
    end

    // The first misaligned access wins; later faults never overwrite it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fault      <= 1'b0;
            r_fault_addr <= 32'h0000_0000;
            r_load_cnt   <= '0;
        end else begin
            if (w_misaligned && !r_fault) begin
                r_fault      <= 1'b1;
                r_fault_addr <= bus.alu_result;
            end
            if (w_valid) begin
                r_load_cnt <= r_load_cnt + 1'b1;
            end
        end
    end

    assign bus.data       = w_data;
    assign bus.misaligned = w_misaligned;
    assign bus.fault      = r_fault;
    assign bus.fault_addr = r_fault_addr;
    assign bus.load_cnt   = r_load_cnt;

    logic w_unused;
    assign w_unused = ^{c_LD_NONE, bus.alu_result[1:0]};
endmodule
`default_nettype wire

// File: tb/tb_load_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_unit
// Purpose  : Self-checking bench for load_unit (table vectors + sequences).
// Revision : 1.0  initial release
// ============================================================================
module tb_load_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    load_unit_if #(.CNT_W(16)) bus16 ();
    load_unit_if #(.CNT_W(2))  bus2  ();

    load_unit #(.CNT_W(16)) u_dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));
    load_unit #(.CNT_W(2))  u_dut2  (.clk(clk), .rst(rst), .bus(bus2.slave));

    typedef struct {
        logic [2:0]  info;
        logic [1:0]  rem;
        logic [31:0] word;
        logic [31:0] exp_data;
        logic        exp_mis;
    } vec_t;

    typedef struct {
        int          idx;
        logic [31:0] exp_data;
        logic        exp_mis;
    } sb_t;

    sb_t  sbq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] info, input logic [1:0] rem,
                         input logic [31:0] word, input logic [31:0] addr);
        bus16.info_load  = info;
        bus16.addr_rem   = rem;
        bus16.addr_data  = word;
        bus16.alu_result = addr;
    endtask

    vec_t vecs[20];

    initial begin
        sb_t e;
        vecs[0]  = '{3'd1, 2'd0, 32'h8877_66F5, 32'hFFFF_FFF5, 1'b0};
        vecs[1]  = '{3'd4, 2'd0, 32'h8877_66F5, 32'h0000_00F5, 1'b0};
        vecs[2]  = '{3'd1, 2'd3, 32'h8877_66F5, 32'hFFFF_FF88, 1'b0};
        vecs[3]  = '{3'd4, 2'd2, 32'h8877_66F5, 32'h0000_0077, 1'b0};
        vecs[4]  = '{3'd4, 2'd1, 32'h8877_66F5, 32'h0000_0066, 1'b0};
        vecs[5]  = '{3'd2, 2'd0, 32'h8001_7FFF, 32'h0000_7FFF, 1'b0};
        vecs[6]  = '{3'd2, 2'd2, 32'h8001_7FFF, 32'hFFFF_8001, 1'b0};
        vecs[7]  = '{3'd5, 2'd2, 32'h8001_7FFF, 32'h0000_8001, 1'b0};
        vecs[8]  = '{3'd2, 2'd1, 32'h8001_7FFF, 32'h0000_017F, 1'b0};
        vecs[9]  = '{3'd2, 2'd3, 32'h8001_7FFF, 32'h0000_0000, 1'b1};
        vecs[10] = '{3'd5, 2'd3, 32'h8001_7FFF, 32'h0000_0000, 1'b1};
        vecs[11] = '{3'd1, 2'd1, 32'h8001_7FFF, 32'h0000_007F, 1'b0};
        vecs[12] = '{3'd3, 2'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
        vecs[13] = '{3'd3, 2'd2, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1};
        vecs[14] = '{3'd3, 2'd1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1};
        vecs[15] = '{3'd6, 2'd0, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
        vecs[16] = '{3'd7, 2'd2, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
        vecs[17] = '{3'd0, 2'd0, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
        vecs[18] = '{3'd1, 2'd2, 32'h0080_0000, 32'hFFFF_FF80, 1'b0};
        vecs[19] = '{3'd5, 2'd0, 32'h0000_F00D, 32'h0000_F00D, 1'b0};

        drive(3'd0, 2'd0, 32'h0, 32'h0);
        bus2.info_load = 3'd0; bus2.addr_rem = 2'd0;
        bus2.addr_data = 32'h0; bus2.alu_result = 32'h0;

        // Reset state while rst is held
        #1;
        check("reset_fault",      {31'h0, bus16.fault}, 32'h0);
        check("reset_fault_addr", bus16.fault_addr,     32'h0);
        check("reset_load_cnt",   {16'h0, bus16.load_cnt}, 32'h0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // Combinational vectors through the scoreboard
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drive(vecs[i].info, vecs[i].rem, vecs[i].word,
                  32'h0000_4000 | {30'h0, vecs[i].rem});
            sbq.push_back('{i, vecs[i].exp_data, vecs[i].exp_mis});
            #1;
            e = sbq.pop_front();
            check($sformatf("vec%0d_data", e.idx), bus16.data, e.exp_data);
            check($sformatf("vec%0d_mis", e.idx), {31'h0, bus16.misaligned}, {31'h0, e.exp_mis});
        end

        // Sticky fault sequence
        @(negedge clk);
        rst = 1'b1;
        drive(3'd0, 2'd0, 32'h0, 32'h0);
        #1 rst = 1'b0;
        drive(3'd3, 2'd2, 32'hDEAD_BEEF, 32'h0000_1002);
        @(posedge clk); #1;
        check("fault_set",      {31'h0, bus16.fault}, 32'h1);
        check("fault_addr_set", bus16.fault_addr,     32'h0000_1002);
        @(negedge clk);
        drive(3'd2, 2'd3, 32'h8001_7FFF, 32'h0000_2003);
        @(posedge clk); #1;
        check("fault_hold",      {31'h0, bus16.fault}, 32'h1);
        check("fault_addr_hold", bus16.fault_addr,     32'h0000_1002);
        check("cnt_two",         {16'h0, bus16.load_cnt}, 32'h2);
        @(negedge clk);
        drive(3'd0, 2'd0, 32'h0, 32'h0);
        rst = 1'b1;
        #1;
        check("async_rst_fault",      {31'h0, bus16.fault}, 32'h0);
        check("async_rst_fault_addr", bus16.fault_addr,     32'h0);
        check("async_rst_cnt",        {16'h0, bus16.load_cnt}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Load counter: 1,0,3,6,5 -> three counted loads
        for (int i = 0; i < 5; i++) begin
            logic [2:0] seq [5];
            seq = '{3'd1, 3'd0, 3'd3, 3'd6, 3'd5};
            @(negedge clk);
            drive(seq[i], 2'd0, 32'h1234_5678, 32'h0000_3000);
        end
        @(negedge clk);
        drive(3'd0, 2'd0, 32'h0, 32'h0);
        #1;
        check("cnt_mixed", {16'h0, bus16.load_cnt}, 32'h3);
        check("no_fault_aligned", {31'h0, bus16.fault}, 32'h0);

        // Narrow counter wraps after six valid loads
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus2.info_load = 3'd4;
        end
        @(negedge clk);
        bus2.info_load = 3'd0;
        #1;
        check("cnt_wrap", {30'h0, bus2.load_cnt}, 32'h2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
